// File: rtl/mem_pkg.sv
// Shared types for the RAM port arbiter: access sizes, request sources and
// arbitration priority states, plus the saturating starvation increment.
package mem_pkg;

    typedef enum logic [1:0] {
        LEN_B = 2'd0,
        LEN_H = 2'd1,
        LEN_W = 2'd2
    } len_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } arb_state_e;

    localparam logic [3:0] STARVE_SAT = 4'd15;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        if (v == STARVE_SAT) begin
            return STARVE_SAT;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// DEPTH-stage {valid, src} shift register that follows each RAM read through
// the fixed RAM latency so its data can be steered back to the issuer.
module resp_tag_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid_i,
    input  logic push_src_i,
    output logic pop_valid_o,
    output logic pop_src_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] src_q;

    generate
        if (DEPTH == 1) begin : g_single
            // Single-stage tag register; a reset drops any read in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    src_q   <= 1'b0;
                end else begin
                    valid_q <= push_valid_i;
                    src_q   <= push_valid_i ? push_src_i : 1'b0;
                end
            end
        end else begin : g_multi
            // Multi-stage tag shift; a reset drops every read in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= '0;
                    src_q   <= '0;
                end else begin
                    valid_q <= {valid_q[DEPTH-2:0], push_valid_i};
                    src_q   <= {src_q[DEPTH-2:0], (push_valid_i ? push_src_i : 1'b0)};
                end
            end
        end
    endgenerate

    assign pop_valid_o = valid_q[DEPTH-1];
    assign pop_src_o   = src_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arb.sv
// Shares one RAM port between instruction fetch and data access: data normally
// wins, a starvation counter forces a fetch grant, read data returns to its issuer.
module mem_port_arb
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_len,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_len,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       rd_push_s;
    logic       rd_src_s;
    logic       pop_valid_s;
    logic       pop_src_s;

    // Grant selection; priority only matters when both sides request.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else if (i_req && d_req) begin
            if (state_q == PRIO_I) begin
                i_gnt = 1'b1;
            end else begin
                d_gnt = 1'b1;
            end
        end else begin
            i_gnt = i_req;
            d_gnt = d_req;
        end
    end

    // Drive the RAM port from the winner and tag reads for the response path.
    always_comb begin
        m_re      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_len     = 2'd0;
        rd_push_s = 1'b0;
        rd_src_s  = 1'(SRC_I);
        if (i_gnt) begin
            m_re      = 1'b1;
            m_addr    = i_addr;
            m_len     = LEN_W;
            rd_push_s = 1'b1;
        end else if (d_gnt) begin
            m_re      = ~d_we;
            m_we      = d_we;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            m_len     = d_len;
            rd_push_s = ~d_we;
            rd_src_s  = 1'(SRC_D);
        end else begin
            rd_push_s = 1'b0;
        end
    end

    // Starvation count and priority next-state; the switch to fetch priority
    // uses the count being loaded so the forced grant lands right after the limit.
    always_comb begin
        starve_d = (i_req && !i_gnt) ? sat_inc4(starve_q) : 4'd0;
        state_d  = state_q;
        case (state_q)
            PRIO_D:  state_d = (starve_d == STARVE_LIM) ? PRIO_I : PRIO_D;
            PRIO_I:  state_d = i_gnt ? PRIO_D : PRIO_I;
            default: state_d = PRIO_D;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= PRIO_D;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    resp_tag_pipe #(
        .DEPTH(RAM_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (rd_push_s),
        .push_src_i   (rd_src_s),
        .pop_valid_o  (pop_valid_s),
        .pop_src_o    (pop_src_s)
    );

    assign i_rvalid = pop_valid_s && (pop_src_s == 1'(SRC_I));
    assign d_rvalid = pop_valid_s && (pop_src_s == 1'(SRC_D));
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arb.sv
// Drives four arbiter instances (RAM_LAT 1/2/3 with STARVE_MAX 3, and RAM_LAT 1
// with STARVE_MAX 15) from shared stimulus and checks them against a rule model.
module tb_mem_port_arb;

    localparam int N = 4;

    function automatic int lat_of(input int g);
        return (g < 3) ? g + 1 : 1;
    endfunction

    function automatic int smax_of(input int g);
        return (g < 3) ? 3 : 15;
    endfunction

    function automatic logic [31:0] init_word(input int a);
        return 32'hA5C3_0000 ^ (32'(a) * 32'h0001_0101);
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [1:0]  d_len = 2'd0;

    logic        ig  [N];
    logic        dg  [N];
    logic        irv [N];
    logic        drv [N];
    logic        mre [N];
    logic        mwe [N];
    logic [31:0] irdata [N];
    logic [31:0] drdata [N];
    logic [31:0] maddr  [N];
    logic [31:0] mwdata [N];
    logic [31:0] mrdata [N];
    logic [1:0]  mlen   [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int LAT = lat_of(g);

            mem_port_arb #(
                .ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT), .STARVE_MAX(smax_of(g))
            ) u_dut (
                .clk(clk), .rst(rst),
                .i_req(i_req), .i_addr(i_addr), .i_gnt(ig[g]),
                .i_rvalid(irv[g]), .i_rdata(irdata[g]),
                .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
                .d_len(d_len), .d_gnt(dg[g]), .d_rvalid(drv[g]), .d_rdata(drdata[g]),
                .m_re(mre[g]), .m_we(mwe[g]), .m_addr(maddr[g]), .m_wdata(mwdata[g]),
                .m_len(mlen[g]), .m_rdata(mrdata[g])
            );

            // Simple RAM with fixed read latency LAT.
            logic [31:0] mem   [256];
            bit          wr_ok [256];
            logic [31:0] pipe  [LAT];
            always @(posedge clk) begin
                if (mwe[g]) begin
                    mem[maddr[g][7:0]]   <= mwdata[g];
                    wr_ok[maddr[g][7:0]] <= 1'b1;
                end
                pipe[0] <= wr_ok[maddr[g][7:0]] ? mem[maddr[g][7:0]] : init_word(int'(maddr[g][7:0]));
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
            assign mrdata[g] = pipe[LAT-1];
        end
    endgenerate

    // Reference model state
    logic [31:0] ref_mem [N][256];
    bit          ref_wr  [N][256];
    int          denied  [N];
    bit          owed    [N];
    bit          sv [N][8];
    bit          ss [N][8];
    logic [31:0] sd [N][8];
    bit          ei [N];
    bit          ed [N];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  gpat = 8'd0;
    logic        gl_i = 1'b0;
    logic        gl_d = 1'b0;

    function automatic logic [31:0] ref_read(input int g, input logic [31:0] a);
        return ref_wr[g][a[7:0]] ? ref_mem[g][a[7:0]] : init_word(int'(a[7:0]));
    endfunction

    task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%h expected=%h cycle=%0d", tag, g, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] dl);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_len = dl;
    endtask

    task automatic step();
        int sl;
        int ds;
        bit exp_iv;
        bit exp_dv;
        sl = cyc % 8;
        @(negedge clk);
        gpat = {gpat[6:0], ig[0]};
        gl_i = ig[0];
        gl_d = dg[0];
        for (int g = 0; g < N; g++) begin
            if (!rst) begin
                ei[g] = 1'b0;
                ed[g] = 1'b0;
            end else begin
                ei[g] = i_req && (!d_req || owed[g]);
                ed[g] = d_req && !ei[g];
            end
            check("i_gnt", g, 32'(ig[g]), 32'(ei[g]));
            check("d_gnt", g, 32'(dg[g]), 32'(ed[g]));
            check("m_re", g, 32'(mre[g]), 32'(ei[g] || (ed[g] && !d_we)));
            check("m_we", g, 32'(mwe[g]), 32'(ed[g] && d_we));
            if (ei[g]) begin
                check("m_addr_i", g, maddr[g], i_addr);
                check("m_len_i", g, 32'(mlen[g]), 32'd2);
            end
            if (ed[g]) begin
                check("m_addr_d", g, maddr[g], d_addr);
                check("m_len_d", g, 32'(mlen[g]), 32'(d_len));
                if (d_we) check("m_wdata", g, mwdata[g], d_wdata);
            end
            exp_iv = rst && sv[g][sl] && !ss[g][sl];
            exp_dv = rst && sv[g][sl] && ss[g][sl];
            check("i_rvalid", g, 32'(irv[g]), 32'(exp_iv));
            check("d_rvalid", g, 32'(drv[g]), 32'(exp_dv));
            if (exp_iv) check("i_rdata", g, irdata[g], sd[g][sl]);
            if (exp_dv) check("d_rdata", g, drdata[g], sd[g][sl]);
        end
        @(posedge clk);
        for (int g = 0; g < N; g++) begin
            sv[g][sl] = 1'b0;
            if (!rst) begin
                denied[g] = 0;
                owed[g]   = 1'b0;
                for (int s = 0; s < 8; s++) sv[g][s] = 1'b0;
            end else begin
                if (ei[g] || (ed[g] && !d_we)) begin
                    ds = (cyc + lat_of(g)) % 8;
                    sv[g][ds] = 1'b1;
                    ss[g][ds] = ed[g];
                    sd[g][ds] = ref_read(g, ei[g] ? i_addr : d_addr);
                end
                if (ed[g] && d_we) begin
                    ref_mem[g][d_addr[7:0]] = d_wdata;
                    ref_wr[g][d_addr[7:0]]  = 1'b1;
                end
                if (i_req && !ei[g]) denied[g] = (denied[g] < 15) ? denied[g] + 1 : 15;
                else                 denied[g] = 0;
                if (ei[g])                           owed[g] = 1'b0;
                else if (denied[g] == smax_of(g))    owed[g] = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Requests during reset must not be granted.
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h14, 32'd0, 2'd2);
        step();
        step();
        rst = 1'b1;
        idle(1);

        // Fetch only.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        step();
        idle(4);

        // Both requesters continuously: D D D I D D D I on the STARVE_MAX=3 instance.
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'd0, 2'd2);
        for (int k = 0; k < 8; k++) step();
        check("grant_seq", 0, 32'(gpat), 32'h0000_0011);
        idle(4);

        // Write then read back.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 2'd2);
        step();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 2'd2);
        step();
        idle(4);

        // Alternating fetch/data reads on consecutive cycles.
        drive(1'b1, 32'h30, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        step();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h34, 32'd0, 2'd1);
        step();
        drive(1'b1, 32'h38, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        step();
        idle(5);

        // Reset one cycle after a read grant discards the response.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h50, 32'd0, 2'd2);
        step();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        idle(4);
        drive(1'b1, 32'h60, 1'b1, 1'b0, 32'h64, 32'd0, 2'd0);
        step();
        idle(3);

        // Long contention exercises STARVE_MAX=15.
        drive(1'b1, 32'h70, 1'b1, 1'b0, 32'h74, 32'd0, 2'd2);
        for (int k = 0; k < 20; k++) step();
        idle(4);

        // Random traffic; requests hold until granted on instance 0.
        for (int k = 0; k < 400; k++) begin
            if (!i_req || gl_i) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = {24'd0, 8'($urandom_range(0, 255))} & 32'h0000_00FC;
            end
            if (!d_req || gl_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = {24'd0, 8'($urandom_range(0, 255))} & 32'h0000_00FC;
                d_wdata = $urandom;
                d_len   = 2'($urandom_range(0, 2));
            end
            step();
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
